// File: rtl/ewb_drain.sv
// ---------------------------------------------------------------------------
// ewb_drain
//   Drain side of the L2 eviction write buffer. Owns the single L2->pmem port
//   and shares it between L2 miss reads and buffer drains. A buffered line is
//   popped only after its memory write has completed, so the buffer's tag
//   check keeps covering the line while it is in flight.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   ewb_empty_i       buffer empty
//   ewb_full_i        buffer full (forces a drain ahead of reads)
//   ewb_data_i        head-of-queue line data
//   ewb_addr_i        head-of-queue line address
//   ewb_yumi_o        one-cycle pop of the head entry
//   l2_read_i         L2 miss read request, held until l2_resp_o
//   l2_addr_i         L2 miss read address
//   l2_rdata_o        read data to L2 (valid with l2_resp_o, else 0)
//   l2_resp_o         one-cycle read completion
//   flush_i           level request to drain the buffer completely
//   flush_done_o      flush requested, buffer empty and FSM idle
//   pmem_read_o       memory read request
//   pmem_write_o      memory write request
//   pmem_address_o    line-aligned memory address
//   pmem_wdata_o      memory write data
//   pmem_rdata_i      memory read data
//   pmem_resp_i       one-cycle memory completion
// ---------------------------------------------------------------------------
module ewb_drain #(
  parameter int width      = 256,
  parameter int starve_max = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ewb_empty_i,
  input  logic             ewb_full_i,
  input  logic [width-1:0] ewb_data_i,
  input  logic [31:0]      ewb_addr_i,
  output logic             ewb_yumi_o,
  input  logic             l2_read_i,
  input  logic [31:0]      l2_addr_i,
  output logic [width-1:0] l2_rdata_o,
  output logic             l2_resp_o,
  input  logic             flush_i,
  output logic             flush_done_o,
  output logic             pmem_read_o,
  output logic             pmem_write_o,
  output logic [31:0]      pmem_address_o,
  output logic [width-1:0] pmem_wdata_o,
  input  logic [width-1:0] pmem_rdata_i,
  input  logic             pmem_resp_i
);

  localparam int starve_w = (starve_max < 1) ? 1 : $clog2(starve_max + 1);
  localparam logic [starve_w-1:0] starve_lim = starve_w'(starve_max);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    POP   = 2'd3
  } state_t;

  state_t              state_reg;
  logic [starve_w-1:0] starve_reg;
  logic                read_reg;
  logic                write_reg;
  logic                yumi_reg;

  logic ewb_busy;
  logic force_drain;

  assign ewb_busy = ~ewb_empty_i;

  // A pending line jumps ahead of reads when the buffer is full, a flush is
  // requested, or reads have already won starve_max times in a row.
  assign force_drain = ewb_busy & (ewb_full_i | flush_i | (starve_reg == starve_lim));

  // Request/pop flags are registered alongside the state, so each one is
  // high for exactly the cycles the FSM spends in the matching state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      starve_reg <= '0;
      read_reg   <= 1'b0;
      write_reg  <= 1'b0;
      yumi_reg   <= 1'b0;
    end else begin
      yumi_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (force_drain) begin
            state_reg  <= WRITE;
            write_reg  <= 1'b1;
            starve_reg <= '0;
          end else if (l2_read_i) begin
            state_reg <= READ;
            read_reg  <= 1'b1;
            // Only reads that bypass waiting lines count toward starvation.
            if (ewb_busy) begin
              if (starve_reg != starve_lim) begin
                starve_reg <= starve_reg + 1'b1;
              end
            end else begin
              starve_reg <= '0;
            end
          end else if (ewb_busy) begin
            state_reg  <= WRITE;
            write_reg  <= 1'b1;
            starve_reg <= '0;
          end
        end
        READ: begin
          if (pmem_resp_i) begin
            state_reg <= IDLE;
            read_reg  <= 1'b0;
          end
        end
        WRITE: begin
          // Head entry stays in the buffer until the write lands.
          if (pmem_resp_i) begin
            state_reg <= POP;
            write_reg <= 1'b0;
            yumi_reg  <= 1'b1;
          end
        end
        POP: begin
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
          read_reg  <= 1'b0;
          write_reg <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    pmem_address_o = 32'h0;
    if (read_reg) begin
      pmem_address_o = {l2_addr_i[31:5], 5'b0};
    end else if (write_reg) begin
      pmem_address_o = {ewb_addr_i[31:5], 5'b0};
    end
  end

  assign pmem_read_o  = read_reg;
  assign pmem_write_o = write_reg;
  assign pmem_wdata_o = {width{write_reg}} & ewb_data_i;
  assign ewb_yumi_o   = yumi_reg;

  // Read data is passed straight through in the completion cycle so L2 sees
  // it with no extra register stage.
  assign l2_resp_o  = read_reg & pmem_resp_i;
  assign l2_rdata_o = {width{l2_resp_o}} & pmem_rdata_i;

  assign flush_done_o = flush_i & ewb_empty_i & (state_reg == IDLE);

  // Line offset bits are never used.
  logic unused_offset;
  assign unused_offset = ^{l2_addr_i[4:0], ewb_addr_i[4:0]};

endmodule

// File: tb/tb_ewb_drain.sv
module tb_ewb_drain;
  localparam int W = 256;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          ewb_empty_i = 1'b1;
  logic          ewb_full_i = 1'b0;
  logic [W-1:0]  ewb_data_i = '0;
  logic [31:0]   ewb_addr_i = '0;
  logic          ewb_yumi_o;
  logic          l2_read_i = 1'b0;
  logic [31:0]   l2_addr_i = '0;
  logic [W-1:0]  l2_rdata_o;
  logic          l2_resp_o;
  logic          flush_i = 1'b0;
  logic          flush_done_o;
  logic          pmem_read_o;
  logic          pmem_write_o;
  logic [31:0]   pmem_address_o;
  logic [W-1:0]  pmem_wdata_o;
  logic [W-1:0]  pmem_rdata_i = '0;
  logic          pmem_resp_i = 1'b0;

  ewb_drain #(.width(W), .starve_max(4)) dut (
    .clk(clk), .rst(rst),
    .ewb_empty_i(ewb_empty_i), .ewb_full_i(ewb_full_i),
    .ewb_data_i(ewb_data_i), .ewb_addr_i(ewb_addr_i), .ewb_yumi_o(ewb_yumi_o),
    .l2_read_i(l2_read_i), .l2_addr_i(l2_addr_i),
    .l2_rdata_o(l2_rdata_o), .l2_resp_o(l2_resp_o),
    .flush_i(flush_i), .flush_done_o(flush_done_o),
    .pmem_read_o(pmem_read_o), .pmem_write_o(pmem_write_o),
    .pmem_address_o(pmem_address_o), .pmem_wdata_o(pmem_wdata_o),
    .pmem_rdata_i(pmem_rdata_i), .pmem_resp_i(pmem_resp_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0]  addr;
    logic [W-1:0] data;
  } ent_t;

  ent_t         buf_q[$];
  ent_t         tmp_ent;
  logic [31:0]  exp_wa[$];
  logic [W-1:0] exp_wd[$];
  logic [W-1:0] exp_rd[$];
  logic [W-1:0] mem [logic [31:0]];
  logic [W-1:0] mon_e;

  int   total = 0;
  int   bad = 0;
  int   lat = 3;
  int   cnt = 0;
  bit   pop_pending = 1'b0;
  bit   full_force = 1'b0;
  int   yumi_cnt = 0;
  int   rd_done = 0;
  int   wr_done = 0;
  bit   prev_wresp = 1'b0;
  int   fd_pops = -1;
  logic [31:0] first_wa = '0;
  bit   first_wa_seen = 1'b0;
  logic [31:0] ev_code = '0;

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] init_val(input logic [31:0] a);
    return {8{a ^ 32'h5A5A_0F0F}};
  endfunction

  function automatic logic [W-1:0] mem_rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return init_val(a);
  endfunction

  // Event order code: two bits per completed transaction, R=01, W=10.
  function automatic logic [31:0] enc(input string s);
    logic [31:0] v = '0;
    for (int i = 0; i < s.len(); i++)
      v = {v[29:0], (s[i] == "R") ? 2'b01 : 2'b10};
    return v;
  endfunction

  function automatic void upd_buf();
    ewb_empty_i = (buf_q.size() == 0);
    ewb_full_i  = (buf_q.size() > 0) && (full_force || buf_q.size() >= 4);
    ewb_addr_i  = (buf_q.size() > 0) ? buf_q[0].addr : 32'h0;
    ewb_data_i  = (buf_q.size() > 0) ? buf_q[0].data : '0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic push_entry(input logic [31:0] a, input logic [W-1:0] d);
    buf_q.push_back('{a, d});
    exp_wa.push_back(a & ~32'h1f);
    exp_wd.push_back(d);
    upd_buf();
  endtask

  // Environment: buffer pop and memory model, updated just after each edge.
  always @(posedge clk) begin
    #1;
    if (pop_pending) begin
      if (buf_q.size() > 0) tmp_ent = buf_q.pop_front();
      pop_pending = 1'b0;
      upd_buf();
    end
    if (rst) begin
      cnt = 0;
      pmem_resp_i = 1'b0;
    end else if (pmem_resp_i) begin
      pmem_resp_i = 1'b0;
      cnt = 0;
      pmem_rdata_i = {8{$urandom}};
    end else if (pmem_read_o || pmem_write_o) begin
      cnt++;
      if (cnt >= lat) begin
        pmem_resp_i = 1'b1;
        if (pmem_write_o) mem[pmem_address_o] = pmem_wdata_o;
        else pmem_rdata_i = mem_rd(pmem_address_o);
      end
    end else begin
      cnt = 0;
      pmem_rdata_i = {8{$urandom}};
    end
  end

  // Monitor: sampled on the falling edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (pmem_resp_i && pmem_read_o) begin
        chk("rd_excl", pmem_write_o, 1'b0);
        chk("rd_queue", exp_rd.size() > 0, 1'b1);
        if (exp_rd.size() > 0) begin
          mon_e = exp_rd.pop_front();
          chk("l2_rdata", l2_rdata_o, mon_e);
        end
        ev_code = {ev_code[29:0], 2'b01};
        rd_done++;
        $display("[%0t] read  addr=%h", $time, pmem_address_o);
      end
      if (l2_resp_o || (pmem_resp_i && pmem_read_o))
        chk("l2_resp", l2_resp_o, pmem_resp_i & pmem_read_o);
      if (pmem_read_o && !pmem_resp_i)
        chk("rdata_gate", l2_rdata_o, '0);
      if (pmem_resp_i && pmem_write_o) begin
        chk("wr_queue", exp_wa.size() > 0, 1'b1);
        if (exp_wa.size() > 0) begin
          chk("wr_addr", pmem_address_o, exp_wa.pop_front());
          chk("wr_data", pmem_wdata_o, exp_wd.pop_front());
        end
        ev_code = {ev_code[29:0], 2'b10};
        wr_done++;
        $display("[%0t] write addr=%h", $time, pmem_address_o);
      end
      if (ewb_yumi_o || prev_wresp) chk("yumi_timing", ewb_yumi_o, prev_wresp);
      if (ewb_yumi_o) begin
        yumi_cnt++;
        pop_pending = 1'b1;
      end
      prev_wresp = pmem_resp_i && pmem_write_o;
      if (pmem_write_o && !first_wa_seen) begin
        first_wa = pmem_address_o;
        first_wa_seen = 1'b1;
      end
      if (flush_done_o && fd_pops < 0) fd_pops = yumi_cnt;
    end
  end

  task automatic do_reset(input bit check_state);
    rst = 1'b1;
    l2_read_i = 1'b0;
    flush_i = 1'b0;
    full_force = 1'b0;
    buf_q.delete();
    exp_wa.delete();
    exp_wd.delete();
    exp_rd.delete();
    upd_buf();
    repeat (2) tick();
    if (check_state) begin
      @(negedge clk);
      chk("rst_read", pmem_read_o, 1'b0);
      chk("rst_write", pmem_write_o, 1'b0);
      chk("rst_yumi", ewb_yumi_o, 1'b0);
      chk("rst_resp", l2_resp_o, 1'b0);
      chk("rst_rdata", l2_rdata_o, '0);
      chk("rst_addr", pmem_address_o, 32'h0);
      chk("rst_wdata", pmem_wdata_o, '0);
      chk("rst_fdone", flush_done_o, 1'b0);
      tick();
    end
    ev_code = '0;
    yumi_cnt = 0;
    rd_done = 0;
    wr_done = 0;
    pop_pending = 1'b0;
    prev_wresp = 1'b0;
    fd_pops = -1;
    first_wa_seen = 1'b0;
    rst = 1'b0;
    tick();
  endtask

  task automatic do_reads(input logic [31:0] a, input int n);
    int target;
    int k;
    l2_addr_i = a;
    l2_read_i = 1'b1;
    for (int i = 0; i < n; i++) begin
      exp_rd.push_back(init_val(a & ~32'h1f));
      target = rd_done + 1;
      k = 0;
      while (rd_done < target && k < 200) begin
        tick();
        k++;
      end
      chk("read_timeout", k < 200, 1'b1);
    end
    l2_read_i = 1'b0;
  endtask

  task automatic wait_quiet(input string tag);
    int k = 0;
    while ((buf_q.size() != 0 || pop_pending) && k < 200) begin
      tick();
      k++;
    end
    chk({tag, "_timeout"}, k < 200, 1'b1);
    repeat (3) tick();
  endtask

  initial begin
    do_reset(1'b1);

    // 1: single drain, latency 3
    lat = 3;
    push_entry(32'h0000_1234, {8{32'hDEAD_0001}});
    wait_quiet("t1");
    chk("t1_addr", first_wa, 32'h0000_1220);
    chk("t1_yumi", yumi_cnt, 1);
    chk("t1_order", ev_code, enc("W"));

    // 2: read served ahead of two queued lines, drains follow in order
    do_reset(1'b0);
    push_entry(32'h0000_2040, {8{32'h1111_2222}});
    push_entry(32'h0000_3060, {8{32'h3333_4444}});
    do_reads(32'h0000_8000, 1);
    wait_quiet("t2");
    chk("t2_order", ev_code, enc("RWW"));
    chk("t2_yumi", yumi_cnt, 2);
    chk("t2_left", exp_wa.size(), 0);

    // 3: starvation limit forces a drain after four reads
    do_reset(1'b0);
    push_entry(32'h0000_5000, {8{32'h5555_AAAA}});
    do_reads(32'h0000_9000, 6);
    wait_quiet("t3");
    chk("t3_order", ev_code, enc("RRRRWRR"));

    // 4: full buffer beats a pending read
    do_reset(1'b0);
    full_force = 1'b1;
    push_entry(32'h0000_6000, {8{32'h6666_0000}});
    do_reads(32'h0000_A000, 1);
    wait_quiet("t4");
    full_force = 1'b0;
    upd_buf();
    chk("t4_order", ev_code, enc("WR"));

    // 5: flush drains all three lines before the read
    do_reset(1'b0);
    lat = 2;
    push_entry(32'h0000_7000, {8{32'h7000_0001}});
    push_entry(32'h0000_7020, {8{32'h7000_0002}});
    push_entry(32'h0000_7040, {8{32'h7000_0003}});
    flush_i = 1'b1;
    do_reads(32'h0000_B000, 1);
    wait_quiet("t5");
    @(negedge clk);
    chk("t5_done_hold", flush_done_o, 1'b1);
    tick();
    flush_i = 1'b0;
    chk("t5_order", ev_code, enc("WWWR"));
    chk("t5_done_pops", fd_pops, 3);

    // 6: reset during a write, then the entry is redrained
    do_reset(1'b0);
    lat = 5;
    push_entry(32'h0000_C000, {8{32'hC0C0_C0C0}});
    begin
      int k = 0;
      while (!pmem_write_o && k < 50) begin
        tick();
        k++;
      end
      chk("t6_write_seen", k < 50, 1'b1);
    end
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("t6_write", pmem_write_o, 1'b0);
    chk("t6_read", pmem_read_o, 1'b0);
    chk("t6_yumi", ewb_yumi_o, 1'b0);
    chk("t6_addr", pmem_address_o, 32'h0);
    chk("t6_no_pop", yumi_cnt, 0);
    chk("t6_no_wr", wr_done, 0);
    tick();
    wait_quiet("t6");
    chk("t6_redrain_yumi", yumi_cnt, 1);
    chk("t6_redrain_wr", wr_done, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

endmodule
